voxel_stream_loader: RTL and testbench

//  Parametrised UART-to-world-cache loader. Consumes the byte stream from uart_receiver and writes

---
 rtl/voxel_stream_loader_pkg.sv | 12 +
 rtl/voxel_addr_counter.sv | 70 +++++++
 rtl/voxel_stream_loader.sv | 174 +++++++++++++++++
 tb/tb_voxel_stream_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_stream_loader_pkg.sv
// Shared types and defaults for the UART-to-world-cache voxel loader.
package voxel_stream_loader_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_CHECK
  } LoaderState;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/voxel_addr_counter.sv
// Nested x/y/z wrap counter (x fastest, z slowest); last_o flags the final block of a sweep.
module voxel_addr_counter #(
  parameter int unsigned SIZE_X = 64,
  parameter int unsigned SIZE_Y = 64,
  parameter int unsigned SIZE_Z = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      clear_i,
  input  logic                      step_i,
  output logic [$clog2(SIZE_X)-1:0] x_o,
  output logic [$clog2(SIZE_Y)-1:0] y_o,
  output logic [$clog2(SIZE_Z)-1:0] z_o,
  output logic                      last_o
);

  localparam int unsigned XW = $clog2(SIZE_X);
  localparam int unsigned YW = $clog2(SIZE_Y);
  localparam int unsigned ZW = $clog2(SIZE_Z);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [ZW-1:0] z_q, z_d;
  logic          x_wrap, y_wrap, z_wrap;

  assign x_wrap = (x_q == XW'(SIZE_X - 1));
  assign y_wrap = (y_q == YW'(SIZE_Y - 1));
  assign z_wrap = (z_q == ZW'(SIZE_Z - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
      z_d = '0;
    end else if (step_i) begin
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d = '0;
          z_d = z_wrap ? '0 : z_q + 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign z_o    = z_q;
  assign last_o = x_wrap && y_wrap && z_wrap;

endmodule

// File: rtl/voxel_stream_loader.sv
// Frames the UART byte stream into voxel cache writes, validating sync, XOR checksum and idle timeout.
module voxel_stream_loader
  import voxel_stream_loader_pkg::*;
#(
  parameter int unsigned SIZE_X         = 64,
  parameter int unsigned SIZE_Y         = 64,
  parameter int unsigned SIZE_Z         = 16,
  parameter int unsigned BLOCK_BITS     = 5,
  parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic                      wr_en,
  output logic [$clog2(SIZE_X)-1:0] wr_x,
  output logic [$clog2(SIZE_Y)-1:0] wr_y,
  output logic [$clog2(SIZE_Z)-1:0] wr_z,
  output logic [BLOCK_BITS-1:0]     wr_data,
  output logic                      busy,
  output logic                      loaded,
  output logic                      frame_done,
  output logic                      frame_error
);

  localparam int unsigned XW = $clog2(SIZE_X);
  localparam int unsigned YW = $clog2(SIZE_Y);
  localparam int unsigned ZW = $clog2(SIZE_Z);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  if (BLOCK_BITS < 1 || BLOCK_BITS > 8) begin : g_bad_block_bits
    $error("voxel_stream_loader: BLOCK_BITS must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("voxel_stream_loader: TIMEOUT_CYCLES must be >= 2");
  end

  LoaderState            state_q, state_d;
  logic [7:0]            chk_q, chk_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  wr_en_q, wr_en_d;
  logic [XW-1:0]         wr_x_q, wr_x_d;
  logic [YW-1:0]         wr_y_q, wr_y_d;
  logic [ZW-1:0]         wr_z_q, wr_z_d;
  logic [BLOCK_BITS-1:0] wr_data_q, wr_data_d;
  logic                  loaded_q, loaded_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  cnt_clear, cnt_step, cnt_last;
  logic [XW-1:0]         cnt_x;
  logic [YW-1:0]         cnt_y;
  logic [ZW-1:0]         cnt_z;

  voxel_addr_counter #(
    .SIZE_X(SIZE_X),
    .SIZE_Y(SIZE_Y),
    .SIZE_Z(SIZE_Z)
  ) u_addr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear_i(cnt_clear),
    .step_i (cnt_step),
    .x_o    (cnt_x),
    .y_o    (cnt_y),
    .z_o    (cnt_z),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    chk_d     = chk_q;
    tmr_d     = tmr_q;
    wr_en_d   = 1'b0;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_z_d    = wr_z_q;
    wr_data_d = wr_data_q;
    loaded_d  = loaded_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;

    unique case (state_q)
      LD_IDLE: begin
        if (byte_valid && byte_in == SYNC_BYTE) begin
          state_d   = LD_LOAD;
          chk_d     = '0;
          tmr_d     = '0;
          cnt_clear = 1'b1;
        end
      end
      LD_LOAD: begin
        if (byte_valid) begin
          wr_en_d   = 1'b1;
          wr_x_d    = cnt_x;
          wr_y_d    = cnt_y;
          wr_z_d    = cnt_z;
          wr_data_d = byte_in[BLOCK_BITS-1:0];
          chk_d     = chk_q ^ byte_in;
          tmr_d     = '0;
          cnt_step  = 1'b1;
          if (cnt_last) state_d = LD_CHECK;
        end
      end
      LD_CHECK: begin
        if (byte_valid) begin
          if (byte_in == chk_q) begin
            done_d   = 1'b1;
            loaded_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          tmr_d   = '0;
          state_d = LD_IDLE;
        end
      end
      default: state_d = LD_IDLE;
    endcase

    // Idle-cycle watchdog for an open frame; any byte_valid above already cleared it.
    if (state_q != LD_IDLE && !byte_valid) begin
      if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d     = 1'b1;
        tmr_d     = '0;
        cnt_clear = 1'b1;
        state_d   = LD_IDLE;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= LD_IDLE;
      chk_q     <= '0;
      tmr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_z_q    <= '0;
      wr_data_q <= '0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      chk_q     <= chk_d;
      tmr_q     <= tmr_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_z_q    <= wr_z_d;
      wr_data_q <= wr_data_d;
      loaded_q  <= loaded_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_x        = wr_x_q;
  assign wr_y        = wr_y_q;
  assign wr_z        = wr_z_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != LD_IDLE);
  assign loaded      = loaded_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_voxel_stream_loader.sv
// Randomised bench for voxel_stream_loader against an index-based frame model.
module tb_voxel_stream_loader;

  localparam int unsigned SX = 4;
  localparam int unsigned SY = 2;
  localparam int unsigned SZ = 2;
  localparam int unsigned BB = 5;
  localparam int unsigned T  = 50;
  localparam int unsigned N  = SX * SY * SZ;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       wr_en;
  logic [1:0] wr_x;
  logic [0:0] wr_y;
  logic [0:0] wr_z;
  logic [4:0] wr_data;
  logic       busy, loaded, frame_done, frame_error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned overlaps = 0;
  logic [63:0] obs[$];
  logic [63:0] exp_q[$];
  logic [7:0]  fr[N];

  bit          m_in_frame = 1'b0;
  bit          m_loaded = 1'b0;
  int unsigned m_idx = 0;
  int unsigned m_idle = 0;
  logic [7:0]  m_chk = '0;

  voxel_stream_loader #(
    .SIZE_X(SX),
    .SIZE_Y(SY),
    .SIZE_Z(SZ),
    .BLOCK_BITS(BB),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .wr_en(wr_en),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_z(wr_z),
    .wr_data(wr_data),
    .busy(busy),
    .loaded(loaded),
    .frame_done(frame_done),
    .frame_error(frame_error)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Event word: kind(1=write,2=done,3=error), x, y, z, data, cycle stamp.
  function automatic logic [63:0] ev(input int kind, input int x, input int y, input int z,
                                     input int d, input int unsigned c);
    return {8'(kind), 8'(x), 8'(y), 8'(z), 8'(d), 24'(c)};
  endfunction

  always @(negedge clk_in) begin
    if (wr_en === 1'b1) obs.push_back(ev(1, int'(wr_x), int'(wr_y), int'(wr_z), int'(wr_data), cyc));
    if (frame_done === 1'b1) obs.push_back(ev(2, 0, 0, 0, 0, cyc));
    if (frame_error === 1'b1) obs.push_back(ev(3, 0, 0, 0, 0, cyc));
    if (int'(wr_en === 1'b1) + int'(frame_done === 1'b1) + int'(frame_error === 1'b1) > 1)
      overlaps++;
  end

  // One clock of stimulus; the model predicts what the DUT must show one cycle later.
  task automatic drive(input bit rst, input bit v, input logic [7:0] b);
    @(negedge clk_in);
    rst_in = rst;
    byte_valid = v;
    byte_in = b;
    if (rst) begin
      m_in_frame = 1'b0;
      m_loaded = 1'b0;
      m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (b == 8'hA5) begin
          m_in_frame = 1'b1;
          m_idx = 0;
          m_chk = '0;
        end
      end else if (m_idx < N) begin
        exp_q.push_back(ev(1, m_idx % SX, (m_idx / SX) % SY, m_idx / (SX * SY),
                           int'(b) % (1 << BB), cyc + 1));
        m_chk ^= b;
        m_idx++;
      end else begin
        if (b == m_chk) begin
          exp_q.push_back(ev(2, 0, 0, 0, 0, cyc + 1));
          m_loaded = 1'b1;
        end else begin
          exp_q.push_back(ev(3, 0, 0, 0, 0, cyc + 1));
        end
        m_in_frame = 1'b0;
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == T) begin
        exp_q.push_back(ev(3, 0, 0, 0, 0, cyc + 1));
        m_in_frame = 1'b0;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    repeat ($urandom_range(gap, 0)) drive(1'b0, 1'b0, 8'($urandom));
    drive(1'b0, 1'b1, b);
  endtask

  task automatic send_frame(input int unsigned gap, input logic [7:0] chk_flip);
    logic [7:0] c;
    c = '0;
    send(8'hA5, gap);
    for (int i = 0; i < N; i++) begin
      send(fr[i], gap);
      c ^= fr[i];
    end
    send(c ^ chk_flip, gap);
  endtask

  task automatic clear_logs();
    @(negedge clk_in);
    #1;
    obs.delete();
    exp_q.delete();
    overlaps = 0;
  endtask

  task automatic test_reset();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    #1;
    n_cmp++;
    if ({wr_en, busy, loaded, frame_done, frame_error} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {wr_en, busy, loaded, frame_done, frame_error});
    end
    n_cmp++;
    if ({wr_x, wr_y, wr_z, wr_data} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_coords: got %h want 000", {wr_x, wr_y, wr_z, wr_data});
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_good_frame();
    clear_logs();
    for (int i = 0; i < N; i++) fr[i] = 8'(i);
    send_frame(2, 8'h00);
    idle(3);
    #1;
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL good_count: got %0d events want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL good_event[%0d]: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (loaded !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL good_status: got loaded=%b busy=%b want loaded=1 busy=0", loaded, busy);
    end
  endtask

  task automatic test_bad_checksum();
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    clear_logs();
    for (int i = 0; i < N; i++) fr[i] = 8'(i);
    send_frame(3, 8'h01);
    idle(3);
    #1;
    n_cmp++;
    if (loaded !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL badchk_status: got loaded=%b busy=%b want loaded=0 busy=0", loaded, busy);
    end
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    send_frame(1, 8'h00);
    idle(3);
    #1;
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL badchk_count: got %0d events want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL badchk_event[%0d]: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (loaded !== 1'b1) begin
      n_bad++;
      $display("FAIL badchk_reload: got loaded=%b want 1", loaded);
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    send(8'hA5, 1);
    for (int i = 0; i < 5; i++) send(8'($urandom), 1);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_busy: got %b want 1", busy);
    end
    idle(T + 5);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_idle: got busy=%b want 0", busy);
    end
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    send_frame(2, 8'h00);
    idle(3);
    #1;
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL timeout_count: got %0d events want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL timeout_event[%0d]: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_junk_and_sync_data();
    clear_logs();
    send(8'h11, 0);
    send(8'h22, 2);
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    fr[5] = 8'hA5;
    send_frame(1, 8'h00);
    idle(3);
    #1;
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL junk_count: got %0d events want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL junk_event[%0d]: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs.size() > 5 && obs[5][31:24] !== 8'h05) begin
      n_bad++;
      $display("FAIL junk_sync_as_data: got %h want 05", obs[5][31:24]);
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    send(8'hA5, 0);
    for (int i = 0; i < 7; i++) send(8'($urandom), 0);
    drive(1'b1, 1'b1, 8'($urandom));
    drive(1'b1, 1'b0, 8'h00);
    #1;
    n_cmp++;
    if ({wr_en, loaded, busy, frame_done, frame_error} !== 5'b0) begin
      n_bad++;
      $display("FAIL midrst_ctrl: got %b want 00000", {wr_en, loaded, busy, frame_done, frame_error});
    end
    n_cmp++;
    if ({wr_x, wr_y, wr_z} !== 4'b0) begin
      n_bad++;
      $display("FAIL midrst_coords: got %h want 0", {wr_x, wr_y, wr_z});
    end
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    send_frame(1, 8'h00);
    idle(3);
    #1;
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL midrst_count: got %0d events want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL midrst_event[%0d]: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    clear_logs();
    c = '0;
    for (int i = 0; i < N; i++) begin
      fr[i] = 8'($urandom);
      c ^= fr[i];
    end
    send(8'hA5, 0);
    for (int i = 0; i < N; i++) begin
      if (i == 10) idle(T - 1);
      send(fr[i], 0);
    end
    send(c, 0);
    idle(3);
    #1;
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d events want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL b2b_event[%0d]: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs.size() == N + 1 && obs[N][63:56] !== 8'd2) begin
      n_bad++;
      $display("FAIL b2b_done: got kind %0d want 2", obs[N][63:56]);
    end
    n_cmp++;
    if (overlaps != 0) begin
      n_bad++;
      $display("FAIL b2b_overlap: got %0d cycles with coincident pulses want 0", overlaps);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_junk_and_sync_data();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
